pc_unit: RTL and testbench

Program-counter stage of the one-cycle CPU, directly upstream of the instruction decoder. It holds the PC, the base address register (BAR) and a small link-register stack, and produces the program-memory address each cycle. The next PC is computed from the decoder's jump controls:

- `pc_rst`, `pc_ld`, `jmp_mode`, `base_reg_offset`
- `base_reg_ld`, `base_reg_data`, `lr_ld`

The instruction fetched at the new PC is decoded combinationally in the following cycle.

---
 rtl/pc_unit.sv | 120 ++++++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter, base address register and link-register stack for the one-cycle CPU.
// Latency: pc, bar_q and stack outputs update one edge after the controls; lr_top/flags are decoded from state.
// No backpressure: en=0 freezes all state, otherwise one instruction is consumed every cycle.
module pc_unit #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pc_rst,
    input  logic             pc_ld,
    input  logic [1:0]       jmp_mode,
    input  logic [WIDTH-1:0] base_reg_offset,
    input  logic             base_reg_ld,
    input  logic [WIDTH-1:0] base_reg_data,
    input  logic             lr_ld,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] bar_q,
    output logic [WIDTH-1:0] lr_top,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam int CW = SP_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

    logic [WIDTH-1:0]    stack [STACK_DEPTH];
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_m1;
    logic [CW-1:0]       cnt_nxt;
    logic [SP_WIDTH-1:0] top_idx;
    logic [SP_WIDTH-1:0] wr_idx;
    logic                wr_en;
    logic                do_pop;
    logic                ovf_set;
    logic                unf_set;
    logic [WIDTH-1:0]    pc_nxt;

    assign stack_empty = (cnt == '0);
    assign stack_full  = (cnt == FULL_CNT);
    assign cnt_m1      = cnt - CW'(1);
    assign top_idx     = cnt_m1[SP_WIDTH-1:0];
    assign lr_top      = stack_empty ? '0 : stack[top_idx];
    assign do_pop      = pc_ld && (jmp_mode == 2'b11);

    always_comb begin
        pc_nxt = pc + WIDTH'(1);
        if (pc_ld) begin
            case (jmp_mode)
                2'b01:   pc_nxt = bar_q + base_reg_offset;
                2'b11:   pc_nxt = lr_top + base_reg_offset;
                default: pc_nxt = base_reg_offset;
            endcase
        end
    end

    // Push+return replaces the top in place; on an empty stack it degrades to a plain push.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cnt[SP_WIDTH-1:0];
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (lr_ld && do_pop) begin
            wr_en = 1'b1;
            if (stack_empty) begin
                cnt_nxt = CW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (lr_ld) begin
            if (stack_full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en   = 1'b1;
                cnt_nxt = cnt + CW'(1);
            end
        end else if (do_pop) begin
            if (stack_empty) begin
                unf_set = 1'b1;
            end else begin
                cnt_nxt = cnt_m1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            bar_q     <= '0;
            cnt       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (en) begin
            if (base_reg_ld) begin
                bar_q <= base_reg_data;
            end
            if (pc_rst) begin
                pc        <= '0;
                cnt       <= '0;
                stack_ovf <= 1'b0;
                stack_unf <= 1'b0;
            end else begin
                pc  <= pc_nxt;
                cnt <= cnt_nxt;
                if (ovf_set) stack_ovf <= 1'b1;
                if (unf_set) stack_unf <= 1'b1;
                if (wr_en)   stack[wr_idx] <= pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: a cumulative table of single-cycle steps plus reset/wrap sequences.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pc_rst;
    logic       pc_ld;
    logic [1:0] jmp_mode;
    logic [7:0] base_reg_offset;
    logic       base_reg_ld;
    logic [7:0] base_reg_data;
    logic       lr_ld;
    logic [7:0] pc;
    logic [7:0] bar_q;
    logic [7:0] lr_top;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_ovf;
    logic       stack_unf;

    int checks = 0;
    int errors = 0;

    pc_unit #(.WIDTH(8), .STACK_DEPTH(4), .SP_WIDTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .pc_rst          (pc_rst),
        .pc_ld           (pc_ld),
        .jmp_mode        (jmp_mode),
        .base_reg_offset (base_reg_offset),
        .base_reg_ld     (base_reg_ld),
        .base_reg_data   (base_reg_data),
        .lr_ld           (lr_ld),
        .pc              (pc),
        .bar_q           (bar_q),
        .lr_top          (lr_top),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .stack_ovf       (stack_ovf),
        .stack_unf       (stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, rst, ld;
        logic [1:0] mode;
        logic [7:0] off;
        logic       bld;
        logic [7:0] bdat;
        logic       lr;
        logic [7:0] e_pc, e_bar, e_top;
        logic       e_empty, e_full, e_ovf, e_unf;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v_en, v_rst, v_ld, input logic [1:0] v_mode,
                                input logic [7:0] v_off, input logic v_bld, input logic [7:0] v_bdat,
                                input logic v_lr, input logic [7:0] x_pc, x_bar, x_top,
                                input logic x_empty, x_full, x_ovf, x_unf);
        vec_t v;
        v.en = v_en; v.rst = v_rst; v.ld = v_ld; v.mode = v_mode; v.off = v_off;
        v.bld = v_bld; v.bdat = v_bdat; v.lr = v_lr;
        v.e_pc = x_pc; v.e_bar = x_bar; v.e_top = x_top;
        v.e_empty = x_empty; v.e_full = x_full; v.e_ovf = x_ovf; v.e_unf = x_unf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en; pc_rst = v.rst; pc_ld = v.ld; jmp_mode = v.mode; base_reg_offset = v.off;
        base_reg_ld = v.bld; base_reg_data = v.bdat; lr_ld = v.lr;
    endtask

    task automatic idle(input logic e);
        en = e; pc_rst = 0; pc_ld = 0; jmp_mode = 0; base_reg_offset = 0;
        base_reg_ld = 0; base_reg_data = 0; lr_ld = 0;
    endtask

    initial begin
        //            en rst ld mode off  bld bdat lr   pc    bar   top  emp ful ovf unf
        vecs[0]  = mk(0, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 2'd0, 8'h00, 1, 8'h40, 0, 8'h02, 8'h40, 8'h00, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 2'd1, 8'h05, 0, 8'h00, 0, 8'h45, 8'h40, 8'h00, 1, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 2'd0, 8'h00, 1, 8'hFE, 0, 8'h46, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 2'd1, 8'h03, 0, 8'h00, 0, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 2'd0, 8'h80, 0, 8'h00, 0, 8'h80, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 2'd2, 8'h10, 0, 8'h00, 0, 8'h10, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[8]  = mk(1, 0, 1, 2'd0, 8'h30, 0, 8'h00, 1, 8'h30, 8'hFE, 8'h10, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h11, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[10] = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 1);
        vecs[11] = mk(1, 1, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 0);
        vecs[13] = mk(1, 0, 1, 2'd0, 8'h11, 0, 8'h00, 1, 8'h11, 8'hFE, 8'h01, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 1, 2'd0, 8'h21, 0, 8'h00, 1, 8'h21, 8'hFE, 8'h11, 0, 0, 0, 0);
        vecs[15] = mk(1, 0, 1, 2'd0, 8'h31, 0, 8'h00, 1, 8'h31, 8'hFE, 8'h21, 0, 0, 0, 0);
        vecs[16] = mk(1, 0, 1, 2'd0, 8'h41, 0, 8'h00, 1, 8'h41, 8'hFE, 8'h31, 0, 1, 0, 0);
        vecs[17] = mk(1, 0, 1, 2'd0, 8'h50, 0, 8'h00, 1, 8'h50, 8'hFE, 8'h31, 0, 1, 1, 0);
        vecs[18] = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h32, 8'hFE, 8'h21, 0, 0, 1, 0);
        vecs[19] = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h22, 8'hFE, 8'h11, 0, 0, 1, 0);
        vecs[20] = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h12, 8'hFE, 8'h01, 0, 0, 1, 0);
        vecs[21] = mk(1, 0, 1, 2'd3, 8'h01, 0, 8'h00, 0, 8'h02, 8'hFE, 8'h00, 1, 0, 1, 0);
        vecs[22] = mk(0, 1, 1, 2'd0, 8'h99, 1, 8'h77, 1, 8'h02, 8'hFE, 8'h00, 1, 0, 1, 0);
        vecs[23] = mk(1, 0, 1, 2'd3, 8'h05, 0, 8'h00, 1, 8'h05, 8'hFE, 8'h02, 0, 0, 1, 0);
        vecs[24] = mk(1, 0, 1, 2'd3, 8'h10, 0, 8'h00, 1, 8'h12, 8'hFE, 8'h05, 0, 0, 1, 0);
        vecs[25] = mk(1, 1, 1, 2'd3, 8'h44, 1, 8'h22, 1, 8'h00, 8'h22, 8'h00, 1, 0, 0, 0);
        vecs[26] = mk(1, 0, 1, 2'd1, 8'h01, 1, 8'h90, 0, 8'h23, 8'h90, 8'h00, 1, 0, 0, 0);
        vecs[27] = mk(1, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h24, 8'h90, 8'h00, 1, 0, 0, 0);

        rst_n = 1'b0;
        idle(1'b0);
        #12;
        check("reset_pc", pc, 8'h00);
        check("reset_bar", bar_q, 8'h00);
        check("reset_top", lr_top, 8'h00);
        check("reset_empty", {7'd0, stack_empty}, 8'h01);
        check("reset_full", {7'd0, stack_full}, 8'h00);
        check("reset_flags", {6'd0, stack_ovf, stack_unf}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("v%0d_bar", i), bar_q, vecs[i].e_bar);
            check($sformatf("v%0d_top", i), lr_top, vecs[i].e_top);
            check($sformatf("v%0d_empty", i), {7'd0, stack_empty}, {7'd0, vecs[i].e_empty});
            check($sformatf("v%0d_full", i), {7'd0, stack_full}, {7'd0, vecs[i].e_full});
            check($sformatf("v%0d_ovf", i), {7'd0, stack_ovf}, {7'd0, vecs[i].e_ovf});
            check($sformatf("v%0d_unf", i), {7'd0, stack_unf}, {7'd0, vecs[i].e_unf});
        end

        // CALL from 0x24, then an async reset lands mid-cycle while another CALL is presented.
        en = 1; pc_ld = 1; jmp_mode = 2'd0; base_reg_offset = 8'h60; lr_ld = 1;
        @(posedge clk);
        #1;
        check("call_pc", pc, 8'h60);
        check("call_top", lr_top, 8'h24);
        base_reg_ld = 1; base_reg_data = 8'h55;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 8'h00);
        check("async_bar", bar_q, 8'h00);
        check("async_top", lr_top, 8'h00);
        check("async_empty", {7'd0, stack_empty}, 8'h01);
        @(posedge clk);
        #1;
        check("held_pc", pc, 8'h00);
        check("held_bar", bar_q, 8'h00);
        idle(1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("count%0d", i), pc, 8'((i + 1) % 256));
        end

        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze%0d", i), pc, 8'h2C);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
